fetch_pc_sequencer: RTL
=======================

# fetch_pc_sequencer

Stage-1 program-counter controller that sequences the PC incrementer datapath and the instruction-memory fetch handshake. It holds the architectural fetch PC, issues one request at a time to instruction memory, and presents each fetched PC and its PC+4 to Stage 2 through a valid/ready slot. It also applies branch/jump redirects from later stages and drains any in-flight request that a redirect makes stale.

## Interface
- WIDTH, 32, PC width in bits (≥ 3).
- RESET_VECTOR, 32'h0000_0000, PC loaded at reset; bits [1:0] must be 0.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall_i  in  1  hold: no new memory request while high.
- redirect_valid  in  1  redirect PC this cycle.
- redirect_pc  in  WIDTH  target; bits [1:0] ignored (treated as 0).
- imem_req  out  1  fetch request.
- imem_addr  out  WIDTH  fetch address, stable while imem_req high.
- imem_ack  in  1  memory completes the request in the same cycle it is high.
- if_valid  out  1  output slot holds a fetched PC.
- if_pc  out  WIDTH  PC of the slot.
- if_pc_plus4  out  WIDTH  if_pc + 4, modulo 2^WIDTH.
- if_ready  in  1  Stage 2 consumes the slot when if_valid && if_ready.
- fetch_count  out  32  present only with FETCH_COUNT_EN.

## Operation
- FSM states:
  - BOOT: entered on reset.
  - IDLE: no request outstanding.
  - REQ: request outstanding for pc.
  - DRAIN: stale request outstanding after a redirect.
- imem_req = (state == REQ || state == DRAIN).
- imem_addr = pc in REQ; the latched stale address in DRAIN.
- BOOT → IDLE unconditionally at the first edge with rst_n high.
- IDLE → REQ when !stall_i && !redirect_valid && (!if_valid || if_ready).
  - The slot is then free: if_valid is cleared at that same edge.
- REQ, imem_ack=1, no redirect:
  - Load if_pc=pc, if_pc_plus4=pc+4, if_valid=1.
  - Update pc ← pc+4; next state IDLE.
- REQ, imem_ack=0, no redirect: stay in REQ; address held.
- Redirect (highest priority, any state except BOOT):
  - pc ← {redirect_pc[WIDTH-1:2], 2'b00}; if_valid ← 0.
  - In REQ with imem_ack=0: go to DRAIN. The stale address is held until ack, the response is discarded, and the next state is IDLE.
  - In REQ with imem_ack=1: the response is discarded; go to IDLE.
  - In DRAIN: pc is updated again and the state stays DRAIN.
- Consumption in IDLE without a new issue (stall_i=1): if_valid && if_ready clears if_valid.
- stall_i never aborts an outstanding request; it only blocks IDLE → REQ.
- Arithmetic: the +4 adder is WIDTH bits wide, carry-out discarded. PC 0xFFFF_FFFC increments to 0x0000_0000.

## Timing
- Reset values:
  - state=BOOT, pc=RESET_VECTOR.
  - imem_req=0, imem_addr=RESET_VECTOR.
  - if_valid=0, if_pc=0, if_pc_plus4=0.
  - fetch_count=0.
- First imem_req: second rising edge after rst_n deasserts (BOOT 1 cycle, then IDLE 1 cycle).
- Zero-wait memory (ack in the cycle req rises): if_valid rises at the next edge.
- Peak throughput with if_ready tied high: one fetch per 2 cycles.
- Redirect-to-request latency from IDLE/REQ-with-ack: redirect at edge N gives imem_req with the new PC from edge N+1.
- rst_n low mid-request: immediate return to the reset values. Any ack arriving later is ignored because imem_req is 0.
- All outputs are registered or decoded from state/pc only. There is no combinational path from the inputs to imem_req, imem_addr or if_*.

## Configuration
- FETCH_COUNT_EN defined:
  - Adds the fetch_count port: a 32-bit count of slot consumptions (if_valid && if_ready).
  - It wraps 0xFFFF_FFFF → 0 and is cleared by reset only.
  - A redirect does not count a discarded slot.
- FETCH_COUNT_EN undefined: no port, no counter logic.

## Test plan
- Reset release with zero-wait memory and if_ready=1:
  - imem_addr sequence is 0x0, 0x4, 0x8, with imem_req high every other cycle.
  - if_pc_plus4 always equals if_pc+4.
- Memory acks after 3 wait cycles:
  - imem_req stays high and imem_addr stays 0x4 for all 4 cycles.
  - if_valid pulses once per fetch.
- Redirect to 0x0000_1003 while a request for 0x8 is waiting, then a delayed ack:
  - The state passes through DRAIN.
  - No if_valid for 0x8.
  - The next imem_addr is 0x0000_1000.
- if_ready=0 for 5 cycles with stall_i=0:
  - if_valid and if_pc hold steady and no new imem_req is issued.
  - Fetch resumes one cycle after if_ready=1.
- Wrap: redirect to 0xFFFF_FFFC with an acked fetch:
  - if_pc_plus4=0x0.
  - The next imem_addr is 0x0.
- rst_n asserted while imem_req is high:
  - All outputs return to reset values asynchronously.
  - With FETCH_COUNT_EN, fetch_count=0 after reset and equals 3 after 3 consumed fetches.

Source files
------------

// File: rtl/fetch_pc_sequencer.sv
// Stage-1 fetch PC sequencer: owns the fetch PC, runs the one-outstanding imem handshake
// and fills the Stage-2 slot. Optional consumption counter enabled by FETCH_COUNT_EN.
module fetch_pc_sequencer #(
   parameter int               WIDTH        = 32,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall_i,
   input  logic             redirect_valid,
   input  logic [WIDTH-1:0] redirect_pc,
   output logic             imem_req,
   output logic [WIDTH-1:0] imem_addr,
   input  logic             imem_ack,
   output logic             if_valid,
   output logic [WIDTH-1:0] if_pc,
   output logic [WIDTH-1:0] if_pc_plus4,
   input  logic             if_ready
`ifdef FETCH_COUNT_EN
   ,
   output logic [31:0]      fetch_count
`endif
);

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      IDLE  = 2'd1,
      REQ   = 2'd2,
      DRAIN = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] stale_addr_q, stale_addr_d;
   logic             if_valid_q, if_valid_d;
   logic [WIDTH-1:0] if_pc_q, if_pc_d;
   logic [WIDTH-1:0] if_pc_plus4_q, if_pc_plus4_d;
   logic [WIDTH-1:0] pc_plus4;
   logic [WIDTH-1:0] redirect_target;

   assign pc_plus4        = pc_q + WIDTH'(4);
   assign redirect_target = redirect_pc & ~WIDTH'(3);

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      stale_addr_d  = stale_addr_q;
      if_valid_d    = if_valid_q;
      if_pc_d       = if_pc_q;
      if_pc_plus4_d = if_pc_plus4_q;
      unique case (state_q)
         BOOT: state_d = IDLE;
         IDLE: begin
            if (redirect_valid) begin
               pc_d       = redirect_target;
               if_valid_d = 1'b0;
            end else begin
               if (if_valid_q && if_ready) if_valid_d = 1'b0;
               if (!stall_i && (!if_valid_q || if_ready)) begin
                  state_d    = REQ;
                  if_valid_d = 1'b0;
               end
            end
         end
         REQ: begin
            if (redirect_valid) begin
               pc_d       = redirect_target;
               if_valid_d = 1'b0;
               if (imem_ack) begin
                  state_d = IDLE;
               end else begin
                  // Memory still owns the old address: keep presenting it until ack.
                  state_d      = DRAIN;
                  stale_addr_d = pc_q;
               end
            end else if (imem_ack) begin
               if_valid_d    = 1'b1;
               if_pc_d       = pc_q;
               if_pc_plus4_d = pc_plus4;
               pc_d          = pc_plus4;
               state_d       = IDLE;
            end
         end
         DRAIN: begin
            if (redirect_valid) begin
               pc_d       = redirect_target;
               if_valid_d = 1'b0;
            end
            // An ack retires the stale request even when a new redirect lands with it.
            if (imem_ack) state_d = IDLE;
         end
         default: state_d = BOOT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= BOOT;
         pc_q          <= RESET_VECTOR;
         stale_addr_q  <= RESET_VECTOR;
         if_valid_q    <= 1'b0;
         if_pc_q       <= '0;
         if_pc_plus4_q <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         stale_addr_q  <= stale_addr_d;
         if_valid_q    <= if_valid_d;
         if_pc_q       <= if_pc_d;
         if_pc_plus4_q <= if_pc_plus4_d;
      end
   end

   assign imem_req    = (state_q == REQ) || (state_q == DRAIN);
   assign imem_addr   = (state_q == DRAIN) ? stale_addr_q : pc_q;
   assign if_valid    = if_valid_q;
   assign if_pc       = if_pc_q;
   assign if_pc_plus4 = if_pc_plus4_q;

`ifdef FETCH_COUNT_EN
   logic        consume;
   logic [31:0] fetch_count_q, fetch_count_d;

   // A slot flushed by a redirect is not a consumption.
   assign consume       = (state_q == IDLE) && !redirect_valid && if_valid_q && if_ready;
   assign fetch_count_d = fetch_count_q + (consume ? 32'd1 : 32'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) fetch_count_q <= '0;
      else        fetch_count_q <= fetch_count_d;
   end

   assign fetch_count = fetch_count_q;
`endif

endmodule
